// File: rtl/tbuf_arb_pkg.sv
// tbuf_arb_pkg: shared state type, widths and parameter range check for the TBUF bus arbiter
// Contents: state_t (IDLE/GRANT/TURN), REQ_W (max requesters), TURN_W, BURST_W, params_ok()
package tbuf_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  localparam int REQ_W = 8;
  localparam int TURN_W = 4;
  localparam int BURST_W = 8;
  function automatic logic params_ok(input int n_req, input int turn_cyc, input int max_burst, input int park_idx);
    return n_req >= 2 && n_req <= REQ_W &&
           turn_cyc >= 1 && turn_cyc < (1 << TURN_W) &&
           max_burst >= 1 && max_burst < (1 << BURST_W) &&
           park_idx >= 0 && park_idx < n_req;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at or after rr_ptr (wrapping)
// Ports: req (requests), rr_ptr (start index) -> any_req, win_idx, win_onehot (zero when no req)
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          any_req,
  output logic [IW-1:0] win_idx,
  output logic [N-1:0]  win_onehot
);
  logic          w_found;
  logic [IW-1:0] w_idx;
  always_comb begin
    w_found = 1'b0;
    w_idx = rr_ptr;
    win_idx = rr_ptr;
    for (int i = 0; i < N; i++) begin
      w_idx = IW'((int'(rr_ptr) + i) % N);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        win_idx = w_idx;
      end
    end
  end
  assign any_req = |req;
  assign win_onehot = any_req ? N'(1) << win_idx : '0;
endmodule

// File: rtl/tbuf_bus_arbiter.sv
// tbuf_bus_arbiter: round-robin arbiter driving TBUF bank enables with guaranteed dead cycles between owners
// Ports: clk, rst_n (async active-low), req[N_REQ] -> gnt[N_REQ] (one-hot), oe[N_REQ] (TBUF EN),
//        owner_idx (current/last owner), bus_busy (|gnt)
// Option: define TBUF_ARB_PARK_EN to park oe[PARK_IDX] on the bus while idle
module tbuf_bus_arbiter
  import tbuf_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_BURST = 8,
  parameter int PARK_IDX = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         oe,
  output logic [$clog2(N_REQ)-1:0] owner_idx,
  output logic                     bus_busy
);
  localparam int IW = $clog2(N_REQ);
  if (!params_ok(N_REQ, TURN_CYC, MAX_BURST, PARK_IDX)) begin : g_param_err
    $error("tbuf_bus_arbiter: parameter out of range");
  end
  state_t             r_state, w_state_nxt;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nxt, r_oe, w_oe_nxt, w_win_oh;
  logic [IW-1:0]      r_owner, w_owner_nxt, r_ptr, w_ptr_nxt, w_win_idx;
  logic [BURST_W-1:0] r_burst, w_burst_nxt;
  logic [TURN_W-1:0]  r_turn, w_turn_nxt;
  logic               w_any, w_release;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req       (req),
    .rr_ptr    (r_ptr),
    .any_req   (w_any),
    .win_idx   (w_win_idx),
    .win_onehot(w_win_oh)
  );
  assign w_release = !req[r_owner] || r_burst == BURST_W'(MAX_BURST);
  // Anything not covered by the GRANT hold/release or a non-final TURN cycle is an arbitration edge.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt = r_gnt;
    w_oe_nxt = r_oe;
    w_owner_nxt = r_owner;
    w_ptr_nxt = r_ptr;
    w_burst_nxt = r_burst;
    w_turn_nxt = r_turn;
    if (r_state == GRANT) begin
      if (w_release) begin
        w_gnt_nxt = '0;
        w_oe_nxt = '0;
        w_ptr_nxt = r_owner == IW'(N_REQ - 1) ? '0 : r_owner + 1'b1;
        w_turn_nxt = TURN_W'(TURN_CYC);
        w_state_nxt = TURN;
      end else begin
        w_burst_nxt = r_burst + 1'b1;
      end
    end else if (r_state == TURN && r_turn != TURN_W'(1)) begin
      w_turn_nxt = r_turn - 1'b1;
    end else if (!w_any) begin
      w_state_nxt = IDLE;
`ifdef TBUF_ARB_PARK_EN
      w_oe_nxt = N_REQ'(1) << PARK_IDX;
`endif
    end
`ifdef TBUF_ARB_PARK_EN
    // A non-park winner must not overlap the parked driver: drop park oe and run a full turnaround first.
    else if (r_state == IDLE && r_oe[PARK_IDX] && w_win_idx != IW'(PARK_IDX)) begin
      w_oe_nxt = '0;
      w_turn_nxt = TURN_W'(TURN_CYC);
      w_state_nxt = TURN;
    end
`endif
    else begin
      w_gnt_nxt = w_win_oh;
      w_oe_nxt = w_win_oh;
      w_owner_nxt = w_win_idx;
      w_burst_nxt = BURST_W'(1);
      w_state_nxt = GRANT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_oe <= '0;
      r_owner <= '0;
      r_ptr <= '0;
      r_burst <= '0;
      r_turn <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt <= w_gnt_nxt;
      r_oe <= w_oe_nxt;
      r_owner <= w_owner_nxt;
      r_ptr <= w_ptr_nxt;
      r_burst <= w_burst_nxt;
      r_turn <= w_turn_nxt;
    end
  end
  assign gnt = r_gnt;
  assign oe = r_oe;
  assign owner_idx = r_owner;
  assign bus_busy = |r_gnt;
endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// tb_tbuf_bus_arbiter: self-checking bench for tbuf_bus_arbiter with scenario tasks and a random run against a tenure-level model
module tb_tbuf_bus_arbiter;
  localparam int N = 4;
  localparam int TC = 3;
  localparam int MB = 4;
  localparam int IW = 2;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt, oe;
  logic [IW-1:0] owner_idx;
  logic          bus_busy;
  int n_checks = 0;
  int n_errors = 0;
  int m_owner, m_len, m_dead, m_ptr, m_last;
  always #5 clk = ~clk;
  tbuf_bus_arbiter #(.N_REQ(N), .TURN_CYC(TC), .MAX_BURST(MB), .PARK_IDX(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .oe       (oe),
    .owner_idx(owner_idx),
    .bus_busy (bus_busy)
  );
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // Tenure-level model: an owner holds until it drops req or uses MB cycles, then TC dead cycles, then round-robin from the next index.
  function automatic void model_reset();
    m_owner = -1;
    m_len = 0;
    m_dead = 0;
    m_ptr = 0;
    m_last = 0;
  endfunction
  function automatic void model_step(input logic [N-1:0] r);
    logic found;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_len == MB) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_dead = TC;
      end else begin
        m_len++;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else begin
      m_dead = 0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && r[(m_ptr + i) % N]) begin
          found = 1'b1;
          m_owner = (m_ptr + i) % N;
          m_last = m_owner;
          m_len = 1;
        end
      end
    end
  endfunction
  task automatic test_reset();
    do_reset();
    n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); end
    n_checks++; if (oe !== '0) begin n_errors++; $display("FAIL reset_oe: got %b want %b", oe, 4'b0000); end
    n_checks++; if (owner_idx !== '0) begin n_errors++; $display("FAIL reset_owner: got %0d want 0", owner_idx); end
    n_checks++; if (bus_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
    req = 4'b0100;
    tick();
    n_checks++; if (gnt !== 4'b0100) begin n_errors++; $display("FAIL first_grant_gnt: got %b want %b", gnt, 4'b0100); end
    n_checks++; if (oe !== 4'b0100) begin n_errors++; $display("FAIL first_grant_oe: got %b want %b", oe, 4'b0100); end
    n_checks++; if (owner_idx !== 2'd2) begin n_errors++; $display("FAIL first_grant_owner: got %0d want 2", owner_idx); end
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL async_reset_gnt: got %b want %b", gnt, 4'b0000); end
    n_checks++; if (oe !== '0) begin n_errors++; $display("FAIL async_reset_oe: got %b want %b", oe, 4'b0000); end
    n_checks++; if (bus_busy !== 1'b0) begin n_errors++; $display("FAIL async_reset_busy: got %b want 0", bus_busy); end
    n_checks++; if (owner_idx !== '0) begin n_errors++; $display("FAIL async_reset_owner: got %0d want 0", owner_idx); end
    req = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL post_reset_gnt: got %b want %b", gnt, 4'b0001); end
    n_checks++; if (bus_busy !== 1'b1) begin n_errors++; $display("FAIL post_reset_busy: got %b want 1", bus_busy); end
  endtask
  task automatic test_fairness();
    logic [N-1:0] exp;
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5 * (MB + TC); t++) begin
      tick();
      exp = (t % (MB + TC)) < MB ? N'(1) << ((t / (MB + TC)) % N) : '0;
      n_checks++; if (gnt !== exp) begin n_errors++; $display("FAIL fairness_gnt cycle %0d: got %b want %b", t, gnt, exp); end
      n_checks++; if (oe !== exp) begin n_errors++; $display("FAIL fairness_oe cycle %0d: got %b want %b", t, oe, exp); end
    end
    req = '0;
  endtask
  task automatic test_turnaround();
    do_reset();
    req = 4'b1010;
    tick();
    n_checks++; if (gnt !== 4'b0010) begin n_errors++; $display("FAIL turn_first_gnt: got %b want %b", gnt, 4'b0010); end
    tick();
    req = 4'b1000;
    tick();
    for (int i = 0; i < TC; i++) begin
      n_checks++; if (oe !== '0) begin n_errors++; $display("FAIL turn_dead_oe cycle %0d: got %b want %b", i, oe, 4'b0000); end
      n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL turn_dead_gnt cycle %0d: got %b want %b", i, gnt, 4'b0000); end
      tick();
    end
    n_checks++; if (oe !== 4'b1000) begin n_errors++; $display("FAIL turn_new_oe: got %b want %b", oe, 4'b1000); end
    n_checks++; if (gnt !== 4'b1000) begin n_errors++; $display("FAIL turn_new_gnt: got %b want %b", gnt, 4'b1000); end
    n_checks++; if (owner_idx !== 2'd3) begin n_errors++; $display("FAIL turn_new_owner: got %0d want 3", owner_idx); end
    req = '0;
  endtask
  task automatic test_burst_sole();
    logic [N-1:0] exp;
    do_reset();
    req = 4'b0100;
    for (int t = 0; t < 3 * (MB + TC); t++) begin
      tick();
      exp = (t % (MB + TC)) < MB ? 4'b0100 : 4'b0000;
      n_checks++; if (gnt !== exp) begin n_errors++; $display("FAIL burst_gnt cycle %0d: got %b want %b", t, gnt, exp); end
      n_checks++; if (bus_busy !== (|exp)) begin n_errors++; $display("FAIL burst_busy cycle %0d: got %b want %b", t, bus_busy, |exp); end
      n_checks++; if (owner_idx !== 2'd2) begin n_errors++; $display("FAIL burst_owner cycle %0d: got %0d want 2", t, owner_idx); end
    end
    req = '0;
  endtask
  task automatic test_random();
    logic [N-1:0] exp;
    do_reset();
    model_reset();
    for (int t = 0; t < 10000; t++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      @(posedge clk);
      model_step(req);
      #1;
      exp = m_owner >= 0 ? N'(1) << m_owner : '0;
      n_checks++; if (gnt !== exp) begin n_errors++; $display("FAIL rand_gnt cycle %0d: got %b want %b", t, gnt, exp); end
      n_checks++; if (oe !== exp) begin n_errors++; $display("FAIL rand_oe cycle %0d: got %b want %b", t, oe, exp); end
      n_checks++; if (owner_idx !== IW'(m_last)) begin n_errors++; $display("FAIL rand_owner cycle %0d: got %0d want %0d", t, owner_idx, m_last); end
      n_checks++; if (bus_busy !== (|exp)) begin n_errors++; $display("FAIL rand_busy cycle %0d: got %b want %b", t, bus_busy, |exp); end
      n_checks++; if (!$onehot0(oe) || gnt !== oe) begin n_errors++; $display("FAIL rand_contention cycle %0d: oe %b gnt %b want onehot0 and equal", t, oe, gnt); end
    end
    req = '0;
  endtask
  initial begin
    test_reset();
    test_fairness();
    test_turnaround();
    test_burst_sole();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
